// File: rtl/msdap_pkg.sv
// Shared types and constants for the audio output path.
package msdap_pkg;

    localparam int WORD_BITS = 40;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } sched_state_t;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } channel_t;

endpackage

// File: rtl/chan_fifo.sv
// Small per-channel result FIFO with a combinational head and a drop strobe.
module chan_fifo #(
    parameter int DATA_W     = 40,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              sClk,
    input  logic              start,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic              drop
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    logic              push_ok, pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign pop_ok  = pop && !empty;
    // A same-cycle pop frees the slot, so a push on a full FIFO still lands.
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && !push_ok;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge sClk or posedge start) begin
        if (start) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (!push_ok && pop_ok) count <= count - 1'b1;
        end
    end

    always_ff @(posedge sClk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/output_scheduler.sv
// Pairs buffered left/right results and feeds them, left first, to the
// single bit-serial output serializer.
module output_scheduler
    import msdap_pkg::*;
#(
    parameter int DATA_W     = WORD_BITS,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic              sClk,
    input  logic              start,
    input  logic              l_valid,
    input  logic [DATA_W-1:0] l_data,
    input  logic              r_valid,
    input  logic [DATA_W-1:0] r_data,
    input  logic              ser_done,
    output logic              ser_en,
    output logic [DATA_W-1:0] ser_data,
    output logic              chan_sel,
    output logic              out_ready,
    output logic              l_full,
    output logic              r_full,
    output logic              overflow,
    output logic              proto_err,
    output logic [CNT_W-1:0]  words_sent
);

    localparam int BC_W = $clog2(DATA_W);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);

    sched_state_t      state;
    channel_t          chan;
    logic [BC_W-1:0]   bit_cnt;
    logic [DATA_W-1:0] l_dout, r_dout;
    logic              l_empty, r_empty, l_drop, r_drop;
    logic              l_pop, r_pop, word_done;

    assign word_done = (state == SEND) && (bit_cnt == BC_LAST);
    assign l_pop     = word_done && (chan == LEFT);
    assign r_pop     = word_done && (chan == RIGHT);

    chan_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_left (
        .sClk(sClk), .start(start), .push(l_valid), .din(l_data), .pop(l_pop),
        .dout(l_dout), .empty(l_empty), .full(l_full), .drop(l_drop)
    );

    chan_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_right (
        .sClk(sClk), .start(start), .push(r_valid), .din(r_data), .pop(r_pop),
        .dout(r_dout), .empty(r_empty), .full(r_full), .drop(r_drop)
    );

    // Decoded from state so an asynchronous reset drops the enable at once.
    assign ser_en    = (state == SEND);
    assign out_ready = ser_en;
    assign chan_sel  = chan;

    always_ff @(posedge sClk or posedge start) begin
        if (start) begin
            state      <= IDLE;
            chan       <= LEFT;
            bit_cnt    <= '0;
            ser_data   <= '0;
            overflow   <= 1'b0;
            proto_err  <= 1'b0;
            words_sent <= '0;
        end else begin
            if (l_drop || r_drop) overflow <= 1'b1;
            case (state)
                IDLE: begin
                    // Only a complete pair starts, so the right head is
                    // guaranteed present once the left word is out.
                    if (!l_empty && !r_empty) begin
                        state    <= LOAD;
                        chan     <= LEFT;
                        ser_data <= l_dout;
                    end
                end
                LOAD: begin
                    bit_cnt <= '0;
                    state   <= SEND;
                end
                SEND: begin
                    bit_cnt <= bit_cnt + 1'b1;
                    if (word_done) begin
                        words_sent <= words_sent + 1'b1;
                        state      <= GAP;
                    end
                end
                GAP: begin
                    if (!ser_done) proto_err <= 1'b1;
                    if (chan == LEFT) begin
                        chan     <= RIGHT;
                        ser_data <= r_dout;
                        state    <= LOAD;
                    end else begin
                        chan  <= LEFT;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_scheduler.sv
// Directed bench for output_scheduler with a behavioural LSB-first serializer.
module tb_output_scheduler;
    import msdap_pkg::*;

    localparam int DW = 40;

    logic          sClk = 1'b0;
    logic          start = 1'b1;
    logic          l_valid = 1'b0, r_valid = 1'b0;
    logic [DW-1:0] l_data = '0, r_data = '0;
    logic          ser_done;
    logic          ser_en, chan_sel, out_ready, l_full, r_full, overflow, proto_err;
    logic [DW-1:0] ser_data;
    logic [15:0]   words_sent;

    int checks = 0;
    int failures = 0;

    output_scheduler #(.DATA_W(DW), .FIFO_DEPTH(2), .CNT_W(16)) dut (
        .sClk(sClk), .start(start),
        .l_valid(l_valid), .l_data(l_data),
        .r_valid(r_valid), .r_data(r_data),
        .ser_done(ser_done), .ser_en(ser_en), .ser_data(ser_data),
        .chan_sel(chan_sel), .out_ready(out_ready),
        .l_full(l_full), .r_full(r_full),
        .overflow(overflow), .proto_err(proto_err), .words_sent(words_sent)
    );

    always #5 sClk = ~sClk;

    // Serializer: shifts one bit per enabled cycle, raises done after the
    // 40th bit, clears it on any disabled edge.
    logic          hold_low = 1'b0;
    logic          done_q;
    int            bcnt;
    logic [DW-1:0] shreg;
    logic [DW-1:0] cap_q[$];

    assign ser_done = done_q;

    always @(posedge sClk or posedge start) begin
        if (start) begin
            done_q <= 1'b0;
            bcnt   <= 0;
            shreg  <= '0;
        end else if (ser_en) begin
            shreg <= {ser_data[bcnt], shreg[DW-1:1]};
            if (bcnt == DW-1) begin
                cap_q.push_back({ser_data[bcnt], shreg[DW-1:1]});
                bcnt   <= 0;
                done_q <= !hold_low;
            end else begin
                bcnt <= bcnt + 1;
            end
        end else begin
            done_q <= 1'b0;
            bcnt   <= 0;
        end
    end

    task automatic tick();
        @(negedge sClk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
        l_valid = 1'b1; l_data = l;
        r_valid = 1'b1; r_data = r;
        tick();
        l_valid = 1'b0;
        r_valid = 1'b0;
    endtask

    task automatic wait_words(input int n, input int bound);
        int k = 0;
        while (words_sent !== 16'(n) && k < bound) begin
            tick();
            k++;
        end
        check("words_sent_reached", {48'd0, words_sent}, 64'(n));
    endtask

    initial begin
        logic [DW-1:0] L0, R0;
        int hi, base;
        int rises[$];
        logic prev;

        L0 = 40'h00000000AA;
        R0 = 40'h5500000000;

        // Reset state
        tick();
        tick();
        check("rst_ser_en", {63'd0, ser_en}, 64'd0);
        check("rst_out_ready", {63'd0, out_ready}, 64'd0);
        check("rst_ser_data", {24'd0, ser_data}, 64'd0);
        check("rst_chan_sel", {63'd0, chan_sel}, 64'd0);
        check("rst_flags", {60'd0, l_full, r_full, overflow, proto_err}, 64'd0);
        check("rst_words", {48'd0, words_sent}, 64'd0);
        start = 1'b0;
        tick();

        // Single pair: latency, framing and serialized contents
        push_pair(L0, R0);
        check("lat_idle", {63'd0, ser_en}, 64'd0);
        tick();
        check("lat_load_en", {63'd0, ser_en}, 64'd0);
        check("lat_load_data", {24'd0, ser_data}, {24'd0, L0});
        tick();
        check("lat_first_en", {63'd0, ser_en}, 64'd1);
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            if (ser_en && out_ready && !chan_sel) hi++;
            tick();
        end
        check("left_en_cycles", 64'(hi), 64'd40);
        check("gap1_en", {63'd0, ser_en}, 64'd0);
        tick();
        check("load2_en", {63'd0, ser_en}, 64'd0);
        check("load2_chan", {63'd0, chan_sel}, 64'd1);
        check("load2_data", {24'd0, ser_data}, {24'd0, R0});
        tick();
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            if (ser_en && out_ready && chan_sel) hi++;
            tick();
        end
        check("right_en_cycles", 64'(hi), 64'd40);
        check("gap2_en", {63'd0, ser_en}, 64'd0);
        check("pair_words", {48'd0, words_sent}, 64'd2);
        check("pair_cap_n", 64'(cap_q.size()), 64'd2);
        check("pair_cap_l", {24'd0, cap_q[0]}, {24'd0, L0});
        check("pair_cap_r", {24'd0, cap_q[1]}, {24'd0, R0});
        check("pair_proto", {63'd0, proto_err}, 64'd0);

        // Unpaired left words: fill, overflow, never sent
        do_reset();
        l_valid = 1'b1; l_data = 40'h11;
        tick();
        check("ovf_full1", {63'd0, l_full}, 64'd0);
        l_data = 40'h22;
        tick();
        check("ovf_full2", {63'd0, l_full}, 64'd1);
        check("ovf_not_yet", {63'd0, overflow}, 64'd0);
        l_data = 40'h33;
        tick();
        l_valid = 1'b0;
        check("ovf_set", {63'd0, overflow}, 64'd1);
        hi = 0;
        for (int i = 0; i < 100; i++) begin
            if (ser_en) hi++;
            tick();
        end
        check("ovf_no_send", 64'(hi), 64'd0);
        check("ovf_sticky", {63'd0, overflow}, 64'd1);
        check("ovf_r_full", {63'd0, r_full}, 64'd0);

        // Two pairs buffered in advance
        do_reset();
        base = cap_q.size();
        push_pair(40'hA1, 40'hB1);
        push_pair(40'hA2, 40'hB2);
        prev = ser_en;
        for (int t = 2; t < 250; t++) begin
            if (ser_en && !prev) rises.push_back(t);
            prev = ser_en;
            tick();
        end
        check("b2b_rise_n", 64'(rises.size()), 64'd4);
        check("b2b_first", 64'(rises[0]), 64'd3);
        check("b2b_word2", 64'(rises[1] - rises[0]), 64'd42);
        check("b2b_pair2", 64'(rises[2] - rises[0]), 64'd85);
        check("b2b_words", {48'd0, words_sent}, 64'd4);
        check("b2b_cap0", {24'd0, cap_q[base]},   64'hA1);
        check("b2b_cap1", {24'd0, cap_q[base+1]}, 64'hB1);
        check("b2b_cap2", {24'd0, cap_q[base+2]}, 64'hA2);
        check("b2b_cap3", {24'd0, cap_q[base+3]}, 64'hB2);

        // Push into full left FIFO on the pop edge
        do_reset();
        base = cap_q.size();
        push_pair(40'hC1, 40'hD1);
        l_valid = 1'b1; l_data = 40'hC2;
        tick();
        l_valid = 1'b0;
        check("pp_full", {63'd0, l_full}, 64'd1);
        tick();
        check("pp_en", {63'd0, ser_en}, 64'd1);
        for (int i = 0; i < 39; i++) tick();
        l_valid = 1'b1; l_data = 40'hC3;
        tick();
        l_valid = 1'b0;
        check("pp_no_ovf", {63'd0, overflow}, 64'd0);
        check("pp_full_after", {63'd0, l_full}, 64'd1);
        check("pp_words", {48'd0, words_sent}, 64'd1);
        r_valid = 1'b1; r_data = 40'hD2;
        tick();
        r_valid = 1'b0;
        wait_words(4, 300);
        check("pp_cap2", {24'd0, cap_q[base+2]}, 64'hC2);
        check("pp_cap3", {24'd0, cap_q[base+3]}, 64'hD2);
        check("pp_left_one", {63'd0, l_full}, 64'd0);

        // Serializer never reports done
        hold_low = 1'b1;
        do_reset();
        push_pair(40'hE1, 40'hF1);
        for (int i = 0; i < 42; i++) tick();
        check("pe_gap_before", {63'd0, proto_err}, 64'd0);
        tick();
        check("pe_set", {63'd0, proto_err}, 64'd1);
        wait_words(2, 200);
        check("pe_sticky", {63'd0, proto_err}, 64'd1);
        hold_low = 1'b0;

        // Asynchronous reset in the middle of a word
        do_reset();
        push_pair(40'h123, 40'h456);
        for (int i = 0; i < 19; i++) tick();
        check("mid_en", {63'd0, ser_en}, 64'd1);
        #2 start = 1'b1;
        #1;
        check("mid_en_drop", {63'd0, ser_en}, 64'd0);
        check("mid_ready", {63'd0, out_ready}, 64'd0);
        check("mid_data", {24'd0, ser_data}, 64'd0);
        check("mid_flags", {59'd0, chan_sel, l_full, r_full, overflow, proto_err}, 64'd0);
        check("mid_words", {48'd0, words_sent}, 64'd0);
        tick();
        start = 1'b0;
        tick();
        base = cap_q.size();
        push_pair(40'h789, 40'hABC);
        wait_words(2, 200);
        check("mid_cap_n", 64'(cap_q.size()), 64'(base + 2));
        check("mid_cap_l", {24'd0, cap_q[base]},   64'h789);
        check("mid_cap_r", {24'd0, cap_q[base+1]}, 64'hABC);
        check("mid_proto", {63'd0, proto_err}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/output_scheduler.md
Name: output_scheduler

Overview:
- Sequences the 40-bit bit-serial output serializer for the stereo audio processor.
- Buffers left and right filter results in two small per-channel FIFOs.
- Sends each sample pair to the single serializer, left word first, then right word.
- Drives the serializer enable for exactly 40 cycles per word, checks its word-sent flag, and reports overflow and protocol errors.

Parameters:
- DATA_W, 40, width of one output word; also the number of enabled cycles per word.
- FIFO_DEPTH, 2, entries per channel FIFO; must be a power of two and at least 2.
- CNT_W, 16, width of the words_sent counter.

Ports:
- sClk  input  1  system clock; all state changes on its rising edge.
- start  input  1  asynchronous, active-high reset.
- l_valid  input  1  one-cycle push strobe for a left result.
- l_data  input  DATA_W  left result; sampled when l_valid=1.
- r_valid  input  1  one-cycle push strobe for a right result.
- r_data  input  DATA_W  right result; sampled when r_valid=1.
- ser_done  input  1  word-sent flag returned by the serializer.
- ser_en  output  1  serializer enable.
- ser_data  output  DATA_W  word presented to the serializer; held stable through LOAD, SEND and GAP.
- chan_sel  output  1  channel of the current word: 0=left, 1=right.
- out_ready  output  1  high while the serializer is shifting (equal to ser_en); framing marker for the board.
- l_full  output  1  left FIFO is full.
- r_full  output  1  right FIFO is full.
- overflow  output  1  sticky; a push was dropped.
- proto_err  output  1  sticky; ser_done was low in a GAP cycle.
- words_sent  output  CNT_W  count of completed words; wraps modulo 2^CNT_W.

Behaviour:
- Reset (start=1, asynchronous): all outputs 0, FIFOs empty, FSM in IDLE, bit counter 0.
  - Reset mid-word aborts the word immediately: ser_en drops with no clock edge and the popped word is lost.
- FIFOs:
  - A push on a full FIFO is dropped and sets overflow.
  - Push and pop on a full FIFO in the same cycle: the pop frees a slot, the push is accepted and overflow is not set.
  - A push on an empty FIFO is not visible to the FSM until the next cycle (registered count).
- FSM states: IDLE, LOAD, SEND, GAP.
  - IDLE: if both FIFOs are non-empty, go to LOAD with chan_sel=0 and ser_data=left head. Otherwise stay; ser_en=0.
  - LOAD (1 cycle): ser_en=0, ser_data stable, bit counter cleared. Go to SEND.
  - SEND (exactly DATA_W cycles): ser_en=1, out_ready=1, bit counter counts 0..DATA_W-1.
    - At count DATA_W-1: pop the chan_sel FIFO and increment words_sent, both on that edge. Go to GAP.
  - GAP (1 cycle): ser_en=0, which clears ser_done in the serializer on this edge. Sample ser_done; if it is 0, set proto_err (continue anyway).
    - If chan_sel=0: go to LOAD with chan_sel=1 and ser_data=right head. That head is guaranteed present because IDLE required a pair.
    - If chan_sel=1: chan_sel returns to 0 and the FSM goes to IDLE.
- Latency: pair available -> first ser_en high in 2 cycles. One pair occupies 84 cycles: LOAD 1 + SEND 40 + GAP 1, twice.
- Back-to-back: if another pair is already buffered, IDLE lasts 1 cycle between pairs.
- Ordering: a right word is never sent before the left word of the same pair. An unpaired word waits indefinitely.
- Arithmetic:
  - The bit counter has width clog2(DATA_W); its terminal value is DATA_W-1.
  - FIFO pointers wrap modulo FIFO_DEPTH; occupancy has width clog2(FIFO_DEPTH)+1.

Decomposition:
- msdap_pkg: WORD_BITS=40; sched_state_t enum {IDLE, LOAD, SEND, GAP}; channel_t enum {LEFT=0, RIGHT=1}.
- Sub-module chan_fifo (DATA_W, FIFO_DEPTH), instantiated twice.
  - Ports: sClk, start, push, din, pop, dout, empty, full, drop.
  - dout is the combinational head.

Test Plan:
- Reset, then push L=40'h00000000AA and R=40'h5500000000 in one cycle:
  - ser_en goes high 2 cycles later for 40 cycles with chan_sel=0, then low for 2 cycles, then high for 40 cycles with chan_sel=1.
  - A serializer model outputs the LSB-first bit streams of both words; words_sent=2; proto_err=0.
- Push 3 left words with no right words:
  - l_full=1 after 2 pushes; the 3rd push sets overflow.
  - ser_en stays 0 throughout.
- Two pairs buffered in advance: exactly 1 IDLE cycle between pairs; the second pair starts 85 cycles after the first ser_en rise.
- Push L on the exact edge where the full left FIFO pops in SEND: the push is accepted and overflow stays 0.
- Serializer model holds ser_done at 0: proto_err sets in the first GAP cycle and is sticky; the sequence still completes.
- Assert start at SEND count 17:
  - ser_en drops immediately and all outputs read 0.
  - After release, a fresh pair transmits normally.
